// File: rtl/bus_fabric_n.sv
// Single-master bus fabric: decodes CPU requests onto NUM_SLV slave channels,
// enforces per-channel X/R/W permissions and serves fixed-latency or handshake slaves.
module bus_fabric_n #(
  parameter int                         NUM_SLV  = 4,
  parameter int                         SEL_LSB  = 16,
  parameter int                         SEL_W    = 4,
  parameter logic [NUM_SLV*SEL_W-1:0]   SLV_SEL  = {4'h5, 4'h4, 4'h1, 4'h0},
  parameter logic [NUM_SLV*SEL_W-1:0]   SLV_MSK  = {4'hF, 4'hF, 4'hE, 4'hE},
  parameter logic [NUM_SLV*2-1:0]       SLV_LAT  = {2'd1, 2'd0, 2'd1, 2'd1},
  parameter logic [NUM_SLV*3-1:0]       SLV_PERM = {3'b011, 3'b011, 3'b100, 3'b100},
  parameter int                         TIMEOUT  = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_valid,
  input  logic                    mem_instr,
  input  logic [31:0]             mem_addr,
  input  logic [3:0]              mem_wstrb,
  input  logic [31:0]             mem_wdata,
  output logic                    mem_ready,
  output logic [31:0]             mem_rdata,
  output logic [NUM_SLV-1:0]      sl_valid,
  output logic [31:0]             sl_addr,
  output logic [3:0]              sl_wstrb,
  output logic [31:0]             sl_wdata,
  input  logic [NUM_SLV-1:0]      sl_ready,
  input  logic [32*NUM_SLV-1:0]   sl_rdata,
  output logic                    bus_err,
  output logic [1:0]              err_cause,
  output logic [31:0]             err_addr
);

  localparam int CH_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

  localparam logic [1:0] CAUSE_DECODE  = 2'd1;
  localparam logic [1:0] CAUSE_PERM    = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {IDLE, ACCESS, CAPT, RESP, ERR} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              hs_q, hs_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              mem_ready_q, mem_ready_d;
  logic              bus_err_q, bus_err_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic [1:0]        err_cause_q, err_cause_d;
  logic [31:0]       err_addr_q, err_addr_d;

  logic [SEL_W-1:0]  req_sel;
  logic              hit;
  logic [CH_W-1:0]   hit_idx;
  logic [2:0]        hit_perm;
  logic [1:0]        hit_lat;
  logic              allowed;
  logic [31:0]       ch_rdata;
  logic [16:0]       cnt_inc;

  assign req_sel = mem_addr[SEL_LSB +: SEL_W];

  // Scan from the top down so the lowest matching channel is the one left standing.
  // NOTE: every variable written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_perm = 3'b000;
    hit_lat  = 2'd0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((req_sel & SLV_MSK[SEL_W*i +: SEL_W]) ==
          (SLV_SEL[SEL_W*i +: SEL_W] & SLV_MSK[SEL_W*i +: SEL_W])) begin
        hit      = 1'b1;
        hit_idx  = CH_W'(i);
        hit_perm = SLV_PERM[3*i +: 3];
        hit_lat  = SLV_LAT[2*i +: 2];
      end
    end
  end

  // Permission bits are {X,R,W}: fetch beats write beats read.
  assign allowed  = mem_instr   ? hit_perm[2] :
                    (|mem_wstrb) ? hit_perm[0] : hit_perm[1];
  assign ch_rdata = sl_rdata[32*ch_q +: 32];
  assign cnt_inc  = 17'(cnt_q) + 17'd1;

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    hs_d        = hs_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wstrb_d     = wstrb_q;
    wdata_d     = wdata_q;
    mem_rdata_d = mem_rdata_q;
    err_cause_d = err_cause_q;
    err_addr_d  = err_addr_q;
    mem_ready_d = 1'b0;
    bus_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_valid) begin
          if (!hit || !allowed) begin
            state_d     = ERR;
            err_cause_d = hit ? CAUSE_PERM : CAUSE_DECODE;
            err_addr_d  = mem_addr;
            mem_rdata_d = '0;
            mem_ready_d = 1'b1;
            bus_err_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            ch_d    = hit_idx;
            hs_d    = (hit_lat == 2'd0);
            cnt_d   = 16'(hit_lat);
            addr_d  = mem_addr;
            wstrb_d = mem_wstrb;
            wdata_d = mem_wdata;
          end
        end
      end

      ACCESS: begin
        if (hs_q) begin
          // A ready arriving on the final allowed cycle still completes normally.
          if (sl_ready[ch_q]) begin
            state_d     = RESP;
            mem_rdata_d = ch_rdata;
            mem_ready_d = 1'b1;
            cnt_d       = '0;
          end else if (cnt_inc == TIMEOUT_W) begin
            state_d     = ERR;
            err_cause_d = CAUSE_TIMEOUT;
            err_addr_d  = addr_q;
            mem_rdata_d = '0;
            mem_ready_d = 1'b1;
            bus_err_d   = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_inc[15:0];
          end
        end else if (cnt_q == 16'd1) begin
          state_d = CAPT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      CAPT: begin
        state_d     = RESP;
        mem_rdata_d = ch_rdata;
        mem_ready_d = 1'b1;
      end

      RESP, ERR: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      hs_q        <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wstrb_q     <= '0;
      wdata_q     <= '0;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      mem_rdata_q <= '0;
      err_cause_q <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      hs_q        <= hs_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wstrb_q     <= wstrb_d;
      wdata_q     <= wdata_d;
      mem_ready_q <= mem_ready_d;
      bus_err_q   <= bus_err_d;
      mem_rdata_q <= mem_rdata_d;
      err_cause_q <= err_cause_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // Slave-side strobes are qualified by ACCESS so an idle bus never shows a write.
  always_comb begin
    sl_valid = '0;
    if (state_q == ACCESS) sl_valid[ch_q] = 1'b1;
  end

  assign sl_addr   = addr_q;
  assign sl_wdata  = wdata_q;
  assign sl_wstrb  = (state_q == ACCESS) ? wstrb_q : 4'b0000;

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_rdata_q;
  assign bus_err   = bus_err_q;
  assign err_cause = err_cause_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_bus_fabric_n.sv
// Directed bench for bus_fabric_n: fixed-latency, handshake, timeout, fault and
// asynchronous-reset scenarios with hand-computed expectations.
module tb_bus_fabric_n;

  localparam int TMO = 8;

  logic          clk;
  logic          reset;
  logic          mem_valid;
  logic          mem_instr;
  logic [31:0]   mem_addr;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_wdata;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [3:0]    sl_valid;
  logic [31:0]   sl_addr;
  logic [3:0]    sl_wstrb;
  logic [31:0]   sl_wdata;
  logic [3:0]    sl_ready;
  logic [127:0]  sl_rdata;
  logic          bus_err;
  logic [1:0]    err_cause;
  logic [31:0]   err_addr;

  int checks = 0;
  int errors = 0;

  bus_fabric_n #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .sl_valid  (sl_valid),
    .sl_addr   (sl_addr),
    .sl_wstrb  (sl_wstrb),
    .sl_wdata  (sl_wdata),
    .sl_ready  (sl_ready),
    .sl_rdata  (sl_rdata),
    .bus_err   (bus_err),
    .err_cause (err_cause),
    .err_addr  (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rdata(input int ch, input logic [31:0] v);
    sl_rdata[32*ch +: 32] = v;
  endtask

  task automatic start_req(input logic instr, input logic [31:0] addr,
                           input logic [3:0] wstrb, input logic [31:0] wdata);
    next_cycle();
    mem_valid = 1'b1;
    mem_instr = instr;
    mem_addr  = addr;
    mem_wstrb = wstrb;
    mem_wdata = wdata;
  endtask

  task automatic finish_req(input string tag);
    next_cycle();
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_wstrb = 4'b0000;
    check({tag, " ready_drop"}, 32'(mem_ready), 32'd0);
  endtask

  task automatic fixed_access(input string tag, input logic instr, input logic [31:0] addr,
                              input logic [3:0] wstrb, input logic [31:0] wdata,
                              input int ch, input int lat, input logic [31:0] rdata);
    logic [3:0] onehot;
    onehot = 4'(1 << ch);
    set_rdata(ch, rdata);
    start_req(instr, addr, wstrb, wdata);
    check({tag, " c0 sl_valid"}, 32'(sl_valid), 32'd0);
    for (int c = 1; c <= lat; c++) begin
      next_cycle();
      check({tag, " sl_valid"}, 32'(sl_valid), 32'(onehot));
      check({tag, " sl_addr"},  sl_addr, addr);
      check({tag, " sl_wstrb"}, 32'(sl_wstrb), 32'(wstrb));
      check({tag, " sl_wdata"}, sl_wdata, wdata);
      check({tag, " early_ready"}, 32'(mem_ready), 32'd0);
      mem_addr = ~addr;
    end
    next_cycle();
    check({tag, " capt sl_valid"}, 32'(sl_valid), 32'd0);
    check({tag, " capt sl_wstrb"}, 32'(sl_wstrb), 32'd0);
    check({tag, " capt sl_addr"},  sl_addr, addr);
    check({tag, " capt ready"},    32'(mem_ready), 32'd0);
    next_cycle();
    check({tag, " mem_ready"}, 32'(mem_ready), 32'd1);
    check({tag, " bus_err"},   32'(bus_err), 32'd0);
    if (wstrb == 4'b0000) check({tag, " mem_rdata"}, mem_rdata, rdata);
    finish_req(tag);
  endtask

  // k = cycle in which sl_ready is raised; 0 means never (timeout expected).
  task automatic hs_access(input string tag, input logic [31:0] addr, input int ch,
                           input int k, input logic [31:0] rdata);
    logic [3:0] onehot;
    onehot = 4'(1 << ch);
    set_rdata(ch, 32'hFFFF_FFFF);
    start_req(1'b0, addr, 4'b0000, 32'h0);
    check({tag, " c0 sl_valid"}, 32'(sl_valid), 32'd0);
    for (int c = 1; c <= TMO; c++) begin
      next_cycle();
      if (c == k) begin
        sl_ready[ch] = 1'b1;
        set_rdata(ch, rdata);
      end
      check({tag, " sl_valid"}, 32'(sl_valid), 32'(onehot));
      check({tag, " early_ready"}, 32'(mem_ready), 32'd0);
      if (c == k) break;
    end
    next_cycle();
    sl_ready = 4'b0000;
    check({tag, " mem_ready"}, 32'(mem_ready), 32'd1);
    check({tag, " sl_valid_off"}, 32'(sl_valid), 32'd0);
    if (k != 0) begin
      check({tag, " bus_err"},   32'(bus_err), 32'd0);
      check({tag, " mem_rdata"}, mem_rdata, rdata);
    end else begin
      check({tag, " bus_err"},   32'(bus_err), 32'd1);
      check({tag, " err_cause"}, 32'(err_cause), 32'd3);
      check({tag, " err_addr"},  err_addr, addr);
      check({tag, " mem_rdata"}, mem_rdata, 32'd0);
    end
    finish_req(tag);
  endtask

  task automatic fault_access(input string tag, input logic instr, input logic [31:0] addr,
                              input logic [3:0] wstrb, input logic [1:0] cause);
    start_req(instr, addr, wstrb, 32'h1111_2222);
    check({tag, " c0 sl_valid"}, 32'(sl_valid), 32'd0);
    next_cycle();
    check({tag, " mem_ready"}, 32'(mem_ready), 32'd1);
    check({tag, " bus_err"},   32'(bus_err), 32'd1);
    check({tag, " err_cause"}, 32'(err_cause), 32'(cause));
    check({tag, " err_addr"},  err_addr, addr);
    check({tag, " mem_rdata"}, mem_rdata, 32'd0);
    check({tag, " sl_valid"},  32'(sl_valid), 32'd0);
    finish_req(tag);
    check({tag, " err_pulse"},  32'(bus_err), 32'd0);
    check({tag, " sticky"},     32'(err_cause), 32'(cause));
    check({tag, " sl_valid_after"}, 32'(sl_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = 32'h0;
    mem_wstrb = 4'b0000;
    mem_wdata = 32'h0;
    sl_ready  = 4'b0000;
    sl_rdata  = '0;

    #12;
    check("rst mem_ready", 32'(mem_ready), 32'd0);
    check("rst sl_valid",  32'(sl_valid), 32'd0);
    check("rst bus_err",   32'(bus_err), 32'd0);
    check("rst mem_rdata", mem_rdata, 32'd0);
    check("rst err_cause", 32'(err_cause), 32'd0);
    check("rst err_addr",  err_addr, 32'd0);
    next_cycle();
    reset = 1'b1;

    fixed_access("rom_fetch", 1'b1, 32'h0001_0040, 4'b0000, 32'h0, 0, 1, 32'h1234_5678);
    fixed_access("ram_write", 1'b0, 32'h0005_0008, 4'b0011, 32'hAABB_CCDD, 3, 1, 32'h3333_3333);
    fixed_access("ram_read",  1'b0, 32'h0005_0100, 4'b0000, 32'h0, 3, 1, 32'h0F0F_1234);

    hs_access("mmi_k4",      32'h0004_0004, 2, 4,   32'h0000_0055);
    hs_access("mmi_k1",      32'h0004_0008, 2, 1,   32'hCAFE_0001);
    hs_access("mmi_timeout", 32'h0004_000C, 2, 0,   32'h0);
    hs_access("mmi_k_tmo",   32'h0004_0010, 2, TMO, 32'h0BAD_F00D);

    fault_access("rom_write",  1'b0, 32'h0000_0000, 4'b1111, 2'd2);
    fault_access("rom_read",   1'b0, 32'h0000_0010, 4'b0000, 2'd2);
    fault_access("mmi_fetch",  1'b1, 32'h0004_0000, 4'b0000, 2'd2);
    fault_access("no_decode",  1'b0, 32'h0009_0000, 4'b0000, 2'd1);

    // Asynchronous reset in cycle 2 of a handshake access.
    start_req(1'b0, 32'h0004_0004, 4'b0000, 32'h0);
    next_cycle();
    next_cycle();
    check("arst pre sl_valid", 32'(sl_valid), 32'b0100);
    #2 reset = 1'b0;
    #1;
    check("arst sl_valid",  32'(sl_valid), 32'd0);
    check("arst mem_ready", 32'(mem_ready), 32'd0);
    check("arst err_cause", 32'(err_cause), 32'd0);
    check("arst err_addr",  err_addr, 32'd0);
    check("arst mem_rdata", mem_rdata, 32'd0);
    mem_valid = 1'b0;
    next_cycle();
    reset = 1'b1;
    fixed_access("post_rst_fetch", 1'b1, 32'h0001_0080, 4'b0000, 32'h0, 0, 1, 32'h8765_4321);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
